// File: rtl/fft_frame_ctrl.sv
// Frame buffer and sequencer around an in-place radix-2 FFT engine: loads a frame
// in bit-reversed order, lends the memory to the engine, then streams bins out in order.
module fft_frame_ctrl #(
  parameter int N = 1024,
  parameter int M = 10,
  parameter int W = 32
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           in_valid,
  input  logic [2*W-1:0] in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [2*W-1:0] out_data,
  output logic [M-1:0]   out_index,
  input  logic           out_ready,
  output logic           fft_start,
  output logic           fft_ack,
  input  logic [3:0]     fft_state,
  input  logic [M-1:0]   fft_i_top,
  input  logic [M-1:0]   fft_i_bot,
  output logic [2*W-1:0] x_top,
  output logic [2*W-1:0] x_bot,
  input  logic [2*W-1:0] y_top,
  input  logic [2*W-1:0] y_bot,
  output logic [2:0]     ctrl_state,
  output logic           fault
);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    KICK    = 3'd1,
    RUN     = 3'd2,
    UNLOAD  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int PROC_MAX = N * M / 2;
  localparam int PW = $clog2(PROC_MAX + 2);
  localparam logic [M-1:0]  LAST       = M'(N - 1);
  localparam logic [PW-1:0] PROC_LIMIT = PW'(PROC_MAX);
  localparam logic [3:0]    ST_DONE    = 4'b0001;
  localparam logic [3:0]    ST_PROC    = 4'b0010;

  state_t         state, next_state;
  logic [M-1:0]   wr_cnt, rd_cnt;
  logic [PW-1:0]  proc_cnt;
  logic           fault_q;
  logic [2*W-1:0] mem [N];

  logic in_fire, out_fire, proc_cyc, proc_over, engine_bad;

  function automatic logic [M-1:0] bitrev(input logic [M-1:0] a);
    logic [M-1:0] r;
    for (int b = 0; b < M; b++) r[b] = a[M-1-b];
    return r;
  endfunction

  assign in_fire    = (state == LOAD) && in_valid;
  assign out_fire   = (state == UNLOAD) && out_ready;
  assign proc_cyc   = (state == RUN) && (fft_state == ST_PROC);
  // A healthy engine finishes in M stages of N/2 butterflies; anything longer is a hang.
  assign proc_over  = proc_cyc && (proc_cnt == PROC_LIMIT);
  assign engine_bad = (state == RUN) && !$onehot(fft_state);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= LOAD;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (in_fire && wr_cnt == LAST) next_state = KICK;
      KICK:    next_state = RUN;
      RUN: begin
        if (engine_bad || proc_over)   next_state = LOAD;
        else if (fft_state == ST_DONE) next_state = UNLOAD;
      end
      UNLOAD:  if (out_fire && rd_cnt == LAST) next_state = RELEASE;
      RELEASE: next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fft_start = 1'b0;
    fft_ack   = 1'b0;
    case (state)
      LOAD:    in_ready  = 1'b1;
      KICK:    fft_start = 1'b1;
      UNLOAD:  out_valid = 1'b1;
      RELEASE: fft_ack   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      proc_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (in_fire) wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + M'(1);
      if (state == RUN) begin
        if (proc_cyc) proc_cnt <= proc_cnt + PW'(1);
        if (engine_bad || proc_over) fault_q <= 1'b1;
        if (fft_state == ST_DONE) rd_cnt <= '0;
      end else begin
        proc_cnt <= '0;
      end
      if (out_fire) rd_cnt <= (rd_cnt == LAST) ? '0 : rd_cnt + M'(1);
    end
  end

  // Frame memory is deliberately not reset; a reset only abandons the frame.
  always_ff @(posedge Clk) begin
    if (in_fire) mem[bitrev(wr_cnt)] <= in_data;
    if (proc_cyc) begin
      mem[fft_i_top] <= y_top;
      mem[fft_i_bot] <= y_bot;
    end
  end

  assign x_top      = mem[fft_i_top];
  assign x_bot      = mem[fft_i_bot];
  assign out_data   = mem[rd_cnt];
  assign out_index  = rd_cnt;
  assign ctrl_state = state;
  assign fault      = fault_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a scripted stub engine; a reference memory
// model tracks where each sample and butterfly result should land.
module tb_fft_frame_ctrl;

  localparam int N = 1024;
  localparam int M = 10;
  localparam int W = 32;
  localparam logic [3:0] ENG_INIT = 4'b1000;
  localparam logic [3:0] ENG_LOAD = 4'b0100;
  localparam logic [3:0] ENG_PROC = 4'b0010;
  localparam logic [3:0] ENG_DONE = 4'b0001;

  logic           Clk = 1'b0;
  logic           Reset;
  logic           in_valid, in_ready;
  logic [2*W-1:0] in_data;
  logic           out_valid, out_ready;
  logic [2*W-1:0] out_data;
  logic [M-1:0]   out_index;
  logic           fft_start, fft_ack;
  logic [3:0]     fft_state;
  logic [M-1:0]   fft_i_top, fft_i_bot;
  logic [2*W-1:0] x_top, x_bot, y_top, y_bot;
  logic [2:0]     ctrl_state;
  logic           fault;

  logic [2*W-1:0] exp_mem [N];
  int compared   = 0;
  int mismatched = 0;
  int both_strobes = 0;

  fft_frame_ctrl #(.N(N), .M(M), .W(W)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_index(out_index), .out_ready(out_ready),
    .fft_start(fft_start), .fft_ack(fft_ack), .fft_state(fft_state),
    .fft_i_top(fft_i_top), .fft_i_bot(fft_i_bot),
    .x_top(x_top), .x_bot(x_bot), .y_top(y_top), .y_bot(y_bot),
    .ctrl_state(ctrl_state), .fault(fault)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (fft_start && fft_ack) both_strobes++;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [M-1:0] rev(input logic [M-1:0] a);
    logic [M-1:0] r = '0;
    logic [M-1:0] t = a;
    for (int b = 0; b < M; b++) begin
      r = {r[M-2:0], t[0]};
      t = t >> 1;
    end
    return r;
  endfunction

  function automatic logic [2*W-1:0] sample_of(input int i, input int seed);
    return {32'(i * 7 + seed * 1000), 32'(-(i + seed))};
  endfunction

  // Streams one frame with in_valid held high; ends at the negedge in RUN.
  task automatic applyStimulus(input int seed);
    int accepts = 0;
    int cycles = 0;
    logic rdy;
    in_valid = 1'b1;
    while (accepts < N && cycles < 4 * N) begin
      rdy = in_ready;
      in_data = sample_of(accepts, seed);
      @(posedge Clk);
      if (rdy) begin
        exp_mem[rev(M'(accepts))] = in_data;
        accepts++;
      end
      cycles++;
      @(negedge Clk);
    end
    checkOutput("accepts", 64'(accepts), 64'(N));
    checkOutput("kick_state", 64'(ctrl_state), 64'(1));
    checkOutput("kick_start", 64'(fft_start), 64'(1));
    checkOutput("kick_in_ready", 64'(in_ready), 64'(0));
    @(negedge Clk);
    checkOutput("run_state", 64'(ctrl_state), 64'(2));
    checkOutput("start_width", 64'(fft_start), 64'(0));
    checkOutput("run_in_ready", 64'(in_ready), 64'(0));
  endtask

  task automatic engine_normal();
    fft_state = ENG_LOAD;
    fft_i_top = M'(1);
    fft_i_bot = M'(512);
    #1;
    checkOutput("x_top_read", x_top, exp_mem[1]);
    checkOutput("x_bot_read", x_bot, exp_mem[512]);
    @(negedge Clk);
    checkOutput("run_holds", 64'(ctrl_state), 64'(2));
    for (int p = 0; p < 4; p++) begin
      fft_state = ENG_PROC;
      fft_i_top = M'(p * 3);
      fft_i_bot = M'(p * 3 + 700);
      y_top = {32'(p + 11), 32'(-p - 1)};
      y_bot = {32'(32'h8000_0000 + p), 32'(32'h7fff_ffff - p)};
      @(posedge Clk);
      exp_mem[fft_i_top] = y_top;
      exp_mem[fft_i_bot] = y_bot;
      @(negedge Clk);
    end
    checkOutput("proc_state", 64'(ctrl_state), 64'(2));
    fft_state = ENG_DONE;
    @(negedge Clk);
    fft_state = ENG_INIT;
    checkOutput("unload_state", 64'(ctrl_state), 64'(3));
  endtask

  // Drains a frame under pseudo-random backpressure while the engine misbehaves with Proc writes.
  task automatic unload_frame();
    int k = 0;
    int cycles = 0;
    int stray = 0;
    logic [63:0]  prev_data = '0;
    logic [M-1:0] prev_idx = '0;
    logic         stalled = 1'b0;
    logic [15:0]  lfsr = 16'hACE1;
    fft_state = ENG_PROC;
    fft_i_top = M'(N - 1);
    fft_i_bot = M'(N - 2);
    y_top = 64'hDEAD_BEEF_0000_0001;
    y_bot = 64'hDEAD_BEEF_0000_0002;
    while (k < N && cycles < 8 * N) begin
      checkOutput("out_valid", 64'(out_valid), 64'(1));
      checkOutput("out_index", 64'(out_index), 64'(k));
      checkOutput("out_data", out_data, exp_mem[k]);
      if (stalled) begin
        checkOutput("stall_data", out_data, prev_data);
        checkOutput("stall_index", 64'(out_index), 64'(prev_idx));
      end
      if (in_ready) stray++;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      out_ready = lfsr[0];
      prev_data = out_data;
      prev_idx  = out_index;
      stalled   = !lfsr[0];
      @(posedge Clk);
      if (out_ready) k++;
      cycles++;
      @(negedge Clk);
    end
    out_ready = 1'b0;
    fft_state = ENG_INIT;
    checkOutput("bins_emitted", 64'(k), 64'(N));
    checkOutput("in_ready_unload", 64'(stray), 64'(0));
    checkOutput("release_state", 64'(ctrl_state), 64'(4));
    checkOutput("release_ack", 64'(fft_ack), 64'(1));
    checkOutput("release_out_valid", 64'(out_valid), 64'(0));
    checkOutput("release_in_ready", 64'(in_ready), 64'(0));
    @(negedge Clk);
    checkOutput("back_to_load", 64'(ctrl_state), 64'(0));
    checkOutput("ack_width", 64'(fft_ack), 64'(0));
    checkOutput("load_in_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    Reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    fft_state = ENG_INIT;
    fft_i_top = '0;
    fft_i_bot = '0;
    y_top = '0;
    y_bot = '0;
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("rst_state", 64'(ctrl_state), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_fault", 64'(fault), 64'(0));
    checkOutput("rst_start", 64'(fft_start), 64'(0));
    checkOutput("rst_ack", 64'(fft_ack), 64'(0));
    Reset = 1'b0;
    @(negedge Clk);

    // Two back-to-back frames with in_valid never dropped.
    applyStimulus(0);
    engine_normal();
    unload_frame();
    applyStimulus(1);
    engine_normal();
    unload_frame();

    // Reset in the middle of a long Proc phase.
    applyStimulus(2);
    fft_state = ENG_PROC;
    fft_i_top = M'(5);
    fft_i_bot = M'(6);
    repeat (1999) @(negedge Clk);
    checkOutput("pre_reset_run", 64'(ctrl_state), 64'(2));
    Reset = 1'b1;
    in_valid = 1'b0;
    @(negedge Clk);
    checkOutput("midrst_state", 64'(ctrl_state), 64'(0));
    checkOutput("midrst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("midrst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("midrst_fault", 64'(fault), 64'(0));
    checkOutput("midrst_start", 64'(fft_start), 64'(0));
    checkOutput("midrst_ack", 64'(fft_ack), 64'(0));
    fft_state = ENG_INIT;
    Reset = 1'b0;
    @(negedge Clk);

    // Engine stuck in Proc: the 5120th cycle is tolerated, the 5121st is not.
    applyStimulus(3);
    fft_state = ENG_PROC;
    fft_i_top = M'(7);
    fft_i_bot = M'(8);
    repeat (N * M / 2) @(negedge Clk);
    checkOutput("limit_no_fault", 64'(fault), 64'(0));
    checkOutput("limit_still_run", 64'(ctrl_state), 64'(2));
    @(negedge Clk);
    checkOutput("hang_fault", 64'(fault), 64'(1));
    checkOutput("hang_state", 64'(ctrl_state), 64'(0));
    checkOutput("hang_in_ready", 64'(in_ready), 64'(1));
    fft_state = ENG_INIT;
    applyStimulus(4);
    engine_normal();
    unload_frame();
    checkOutput("fault_sticky", 64'(fault), 64'(1));

    // Non-one-hot engine state is also a fault; Reset clears the flag.
    in_valid = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("fault_cleared", 64'(fault), 64'(0));
    Reset = 1'b0;
    @(negedge Clk);
    applyStimulus(5);
    fft_state = 4'b0011;
    @(negedge Clk);
    checkOutput("onehot_fault", 64'(fault), 64'(1));
    checkOutput("onehot_state", 64'(ctrl_state), 64'(0));
    fft_state = ENG_INIT;
    in_valid = 1'b0;
    @(negedge Clk);

    checkOutput("start_ack_overlap", 64'(both_strobes), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
